// File: rtl/param_memory.sv
// Line-oriented memory model with a fixed access latency and a burst beat interface.
// An open-page register shortens the latency of accesses that stay in the last page.
module param_memory #(
    parameter int unsigned DELAY      = 50,
    parameter int unsigned PAGE_DELAY = 25,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned LINE_BITS  = 256,
    parameter int unsigned NUM_LINES  = 512
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           mem_read,
    input  logic                           mem_write,
    input  logic [31:0]                    mem_addr,
    input  logic [LINE_BITS/BURST_LEN-1:0] mem_wdata,
    output logic [LINE_BITS/BURST_LEN-1:0] mem_rdata,
    output logic                           mem_resp
);

    localparam int unsigned BeatW    = LINE_BITS / BURST_LEN;
    localparam int unsigned IdxBits  = $clog2(NUM_LINES);
    localparam int unsigned BeatBits = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned CntBits  = $clog2(DELAY + 1);

    typedef logic [BURST_LEN-1:0][BeatW-1:0] line_t;
    typedef enum logic [1:0] {StIdle, StWait, StBurst} state_e;

    line_t mem [NUM_LINES];

    state_e              state_q, state_d;
    logic                op_write_q, op_write_d;
    logic [IdxBits-1:0]  line_q, line_d;
    logic [CntBits-1:0]  delay_q, delay_d;
    logic [BeatBits-1:0] beat_q, beat_d;
    logic [IdxBits-4:0]  page_q, page_d;
    logic                page_valid_q, page_valid_d;
    logic                resp_q, resp_d;
    logic [BeatW-1:0]    rdata_q, rdata_d;

    logic [IdxBits-1:0]  req_line;
    logic [IdxBits-4:0]  req_page;
    logic [CntBits-1:0]  req_lat;
    logic                unused_addr;

    assign req_line    = mem_addr[IdxBits+4:5];
    assign req_page    = req_line[IdxBits-1:3];
    assign req_lat     = (page_valid_q && (req_page == page_q)) ? CntBits'(PAGE_DELAY)
                                                                : CntBits'(DELAY);
    // Upper address bits alias; the low five select a byte within the line.
    assign unused_addr = ^{mem_addr[31:IdxBits+5], mem_addr[4:0]};

    always_comb begin
        state_d      = state_q;
        op_write_d   = op_write_q;
        line_d       = line_q;
        delay_d      = delay_q;
        beat_d       = beat_q;
        page_d       = page_q;
        page_valid_d = page_valid_q;
        resp_d       = resp_q;
        rdata_d      = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (mem_read || mem_write) begin
                    op_write_d   = !mem_read;
                    line_d       = req_line;
                    page_d       = req_page;
                    page_valid_d = 1'b1;
                    beat_d       = '0;
                    // A latency of one puts the first beat right after the accepting edge.
                    if (req_lat == CntBits'(1)) begin
                        state_d = StBurst;
                        resp_d  = 1'b1;
                        rdata_d = mem_read ? mem[req_line][0] : '0;
                    end else begin
                        state_d = StWait;
                        delay_d = req_lat - CntBits'(1);
                    end
                end
            end
            StWait: begin
                if (delay_q == CntBits'(1)) begin
                    state_d = StBurst;
                    delay_d = '0;
                    beat_d  = '0;
                    resp_d  = 1'b1;
                    rdata_d = op_write_q ? '0 : mem[line_q][0];
                end else begin
                    delay_d = delay_q - CntBits'(1);
                end
            end
            StBurst: begin
                if (beat_q == BeatBits'(BURST_LEN - 1)) begin
                    state_d = StIdle;
                    beat_d  = '0;
                    resp_d  = 1'b0;
                    rdata_d = '0;
                end else begin
                    beat_d  = beat_q + BeatBits'(1);
                    rdata_d = op_write_q ? '0 : mem[line_q][beat_q + BeatBits'(1)];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            op_write_q   <= 1'b0;
            line_q       <= '0;
            delay_q      <= '0;
            beat_q       <= '0;
            page_q       <= '0;
            page_valid_q <= 1'b0;
            resp_q       <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            op_write_q   <= op_write_d;
            line_q       <= line_d;
            delay_q      <= delay_d;
            beat_q       <= beat_d;
            page_q       <= page_d;
            page_valid_q <= page_valid_d;
            resp_q       <= resp_d;
            rdata_q      <= rdata_d;
        end
    end

    // Storage is not reset; reset forces StIdle, so an aborted write keeps its earlier beats.
    always_ff @(posedge clk) begin
        if (state_q == StBurst && op_write_q) begin
            mem[line_q][beat_q] <= mem_wdata;
        end
    end

    assign mem_resp  = resp_q;
    assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_param_memory.sv
// Directed bench for param_memory with a beat scoreboard and latency checks.
// The monitor pops expected beats whenever mem_resp is high.
module tb_param_memory;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_resp;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit          chk;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];

    localparam logic [63:0] Junk = 64'hdead_beef_cafe_f00d;

    logic [3:0][63:0] line_b;
    logic [3:0][63:0] line_c;
    logic [3:0][63:0] line_d;

    param_memory #(
        .DELAY     (10),
        .PAGE_DELAY(5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_resp (mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_resp) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: rdata=%h with no expected beat queued",
                             mem_rdata);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.chk) begin
                        n_cmp++;
                        if (mem_rdata !== e.data) begin
                            n_bad++;
                            $display("FAIL read_beat: got %h expected %h", mem_rdata, e.data);
                        end
                    end
                end
            end else begin
                n_cmp++;
                if (mem_rdata !== 64'h0) begin
                    n_bad++;
                    $display("FAIL idle_rdata: got %h expected 0", mem_rdata);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic expect_beats(input bit chk, input logic [3:0][63:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.chk  = chk;
            e.data = d[i];
            sb.push_back(e);
        end
    endtask

    // abort_beat < 0: full burst; otherwise reset is raised as that beat begins.
    task automatic access(input bit rd, input bit wr, input logic [31:0] addr, input int exp_lat,
                          input logic [3:0][63:0] wb, input bit chg, input logic [31:0] addr2,
                          input int abort_beat);
        int k;
        @(negedge clk);
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = addr;
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (chg) mem_addr = addr2;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!mem_resp && k < 200);
        check("latency", 64'(k), 64'(exp_lat));
        if (!mem_resp) return;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                if (i == abort_beat) begin
                    @(posedge clk);
                    #2;
                    rst = 1'b1;
                    #1;
                    check("abort_resp", 64'(mem_resp), 64'h0);
                    check("abort_rdata", mem_rdata, 64'h0);
                    @(negedge clk);
                    @(negedge clk);
                    rst = 1'b0;
                    return;
                end
                @(negedge clk);
            end
            mem_wdata = (wr && !rd) ? wb[i] : Junk;
        end
        @(negedge clk);
        mem_wdata = Junk;
        check("burst_end", 64'(mem_resp), 64'h0);
        @(negedge clk);
    endtask

    initial begin
        line_b = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        line_c = {64'hc3c3_0000_0000_0003, 64'hc2c2_0000_0000_0002,
                  64'hc1c1_0000_0000_0001, 64'hc0c0_0000_0000_0000};
        line_d = {64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210,
                  64'h5a5a_5a5a_a5a5_a5a5, 64'h0f0f_0f0f_f0f0_f0f0};
        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = Junk;
        repeat (3) @(negedge clk);
        check("reset_resp", 64'(mem_resp), 64'h0);
        check("reset_rdata", mem_rdata, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        // Write line 0x100 from a cold page, read it back on the open page.
        expect_beats(1'b0, line_b, 4);
        access(1'b0, 1'b1, 32'h100, 10, line_b, 1'b0, 32'h0, -1);
        expect_beats(1'b1, line_b, 4);
        access(1'b1, 1'b0, 32'h100, 5, line_b, 1'b0, 32'h0, -1);

        // Same page neighbour, then a different page.
        expect_beats(1'b0, line_c, 4);
        access(1'b0, 1'b1, 32'h120, 5, line_c, 1'b0, 32'h0, -1);
        expect_beats(1'b1, line_c, 4);
        access(1'b1, 1'b0, 32'h120, 5, line_c, 1'b0, 32'h0, -1);
        expect_beats(1'b0, line_d, 4);
        access(1'b1, 1'b0, 32'h300, 10, line_d, 1'b0, 32'h0, -1);

        // Alias of 0x100 from page 3 back to page 1.
        expect_beats(1'b1, line_b, 4);
        access(1'b1, 1'b0, 32'h4100, 10, line_b, 1'b0, 32'h0, -1);

        // Read wins over write; storage must be untouched afterwards.
        expect_beats(1'b1, line_b, 4);
        access(1'b1, 1'b1, 32'h100, 5, line_d, 1'b0, 32'h0, -1);
        expect_beats(1'b1, line_b, 4);
        access(1'b1, 1'b0, 32'h100, 5, line_b, 1'b0, 32'h0, -1);

        // Address moves during WAIT; data follows the latched address.
        expect_beats(1'b1, line_c, 4);
        access(1'b1, 1'b0, 32'h120, 5, line_c, 1'b1, 32'h300, -1);

        // Write a new page, read it back.
        expect_beats(1'b0, line_d, 4);
        access(1'b0, 1'b1, 32'h2e0, 10, line_d, 1'b0, 32'h0, -1);
        expect_beats(1'b1, line_d, 4);
        access(1'b1, 1'b0, 32'h2e0, 5, line_d, 1'b0, 32'h0, -1);

        // Reset during beat 2, then the open page must be forgotten.
        expect_beats(1'b1, line_b, 2);
        access(1'b1, 1'b0, 32'h100, 10, line_b, 1'b0, 32'h0, 2);
        expect_beats(1'b1, line_b, 4);
        access(1'b1, 1'b0, 32'h100, 10, line_b, 1'b0, 32'h0, -1);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/param_memory.md
PARAM_MEMORY -- requirements
Module: param_memory

Interface
REQ-001 SHALL have parameter DELAY, default 50, meaning full-access latency in cycles from request to first beat on a page miss (minimum 1).
REQ-002 SHALL have parameter PAGE_DELAY, default 25, meaning latency in cycles on an open-page hit (minimum 1, at most DELAY).
REQ-003 SHALL have parameter BURST_LEN, default 4, meaning beats per line transfer.
REQ-004 SHALL have parameter LINE_BITS, default 256, meaning line width; beat width is LINE_BITS/BURST_LEN, which is 64 at the defaults.
REQ-005 SHALL have parameter NUM_LINES, default 512, meaning storage depth in lines; the page size is fixed at 8 lines (256 bytes).
REQ-006 SHALL have ports: clk input 1, the single clock, rising-edge active.
REQ-007 SHALL have ports: rst input 1, reset that is asynchronous and active-high.
REQ-008 SHALL have ports: mem_read input 1, the line read request.
REQ-009 SHALL have ports: mem_write input 1, the line write request.
REQ-010 SHALL have ports: mem_addr input 32, the byte address.
REQ-011 SHALL have ports: mem_wdata input LINE_BITS/BURST_LEN, the write beat.
REQ-012 SHALL have ports: mem_rdata output LINE_BITS/BURST_LEN, the read beat.
REQ-013 SHALL have ports: mem_resp output 1, the beat-valid strobe.

Function
REQ-014 SHALL map addresses as follows: line index = mem_addr[log2(NUM_LINES)+4:5]; bits [4:0] are ignored; upper bits are ignored, so addresses alias modulo NUM_LINES*32 bytes.
REQ-015 SHALL derive the page number from the line index with the low 3 bits dropped.
REQ-016 SHALL implement an FSM with three states: IDLE, WAIT, BURST.
REQ-017 In IDLE, with mem_read or mem_write high at a clock edge, SHALL latch the operation, line index and latency, then enter WAIT.
REQ-018 SHALL give mem_read priority when mem_read and mem_write are both high.
REQ-019 SHALL set latency L = PAGE_DELAY if the page equals the open-page register and that register is valid; otherwise L = DELAY.
REQ-020 SHALL update the open-page register to the request page and mark it valid on every accepted request.
REQ-021 In WAIT, SHALL count down; mem_resp SHALL first be high during the L-th cycle after the accepting edge.
REQ-022 In BURST, SHALL hold mem_resp high for exactly BURST_LEN consecutive cycles, beat i = 0..BURST_LEN-1, then return to IDLE.
REQ-023 On a read, mem_rdata on beat i SHALL equal line bits [i*W +: W], where W is the beat width.
REQ-024 On a read, mem_rdata SHALL be registered and SHALL be 0 whenever mem_resp is low.
REQ-025 On a write, mem_wdata SHALL be sampled at each edge where mem_resp is high and stored into bits [i*W +: W] of the latched line.
REQ-026 SHALL latch request fields at acceptance; changes to mem_addr, mem_read or mem_write during WAIT/BURST SHALL be ignored.
REQ-027 The requester deasserts its request on the cycle after the last beat; a request still high in IDLE starts a new transaction.
REQ-028 SHALL provide no back-to-back overlap: at least one IDLE cycle between transactions.
REQ-029 SHALL implement storage as a NUM_LINES x LINE_BITS array with no byte enables; writes always cover the whole line.

Reset
REQ-030 While rst is high, SHALL force: state IDLE, mem_resp 0, mem_rdata 0, beat counter 0, delay counter 0, open-page register invalid.
REQ-031 SHALL abort any transaction in progress when rst asserts mid-operation; a partially written line SHALL keep the beats already stored.
REQ-032 Storage contents SHALL NOT be cleared by reset and are undefined until written.

Verification (DELAY=10, PAGE_DELAY=5, defaults otherwise)
REQ-033 Write 0x100 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44, after reset -> first mem_resp 10 cycles after accept, 4 resp cycles; a later read of 0x100 returns the same beats in order.
REQ-034 Read 0x120 after 0x100 (same page) -> first mem_resp 5 cycles after accept; read 0x300 (new page) -> 10 cycles.
REQ-035 Read 0x4100 -> aliases line 0x100; data equal to REQ-033 beats.
REQ-036 mem_read and mem_write high together at address 0x100 -> read performed, storage unchanged.
REQ-037 Assert rst during beat 2 of a read -> mem_resp and mem_rdata 0 immediately; next access takes DELAY cycles (open page invalid).
REQ-038 Change mem_addr during WAIT -> data returned for the originally latched address.
